// File: rtl/posit_decoded_mul_if.sv
// -----------------------------------------------------------------------------
// posit_decoded_mul_if
//   Bundles the operand-side and result-side valid/ready channels of the
//   decoded posit multiplier.
//   Operand side : in_valid/in_ready, per-operand sign, regime, exponent,
//                  fraction and zero/NaR flags.
//   Result side  : out_valid/out_ready, out_sign, out_scale, out_mant,
//                  out_zero, out_nar.
//   slave  modport : the multiplier core.
//   master modport : the producer/consumer around the core.
// -----------------------------------------------------------------------------
interface posit_decoded_mul_if #(
  parameter int width = 32,
  parameter int es    = 2
);
  localparam int SW = width + es + 2;

  logic               in_valid;
  logic               in_ready;
  logic               a_sign,     b_sign;
  logic [width-2:0]   a_regime,   b_regime;
  logic [width-2:0]   a_exponent, b_exponent;
  logic [width-2:0]   a_fraction, b_fraction;
  logic               a_zero,     b_zero;
  logic               a_nar,      b_nar;

  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic [SW-1:0]      out_scale;
  logic [2*width-1:0] out_mant;
  logic               out_zero;
  logic               out_nar;

  modport slave (
    input  in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
           a_fraction, b_fraction, a_zero, b_zero, a_nar, b_nar, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_mant, out_zero, out_nar
  );

  modport master (
    output in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
           a_fraction, b_fraction, a_zero, b_zero, a_nar, b_nar, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_mant, out_zero, out_nar
  );
endinterface

// File: rtl/posit_decoded_mul.sv
// -----------------------------------------------------------------------------
// posit_decoded_mul
//   Multi-cycle multiplier for posit operands already split into fields.
//   Produces an unrounded, normalised product (sign, scale, mantissa) for the
//   downstream rounding/encode stage. The mantissa product is built with a
//   radix-2 shift-add loop, one multiplier bit per cycle.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - operand and result valid/ready channels (slave side)
//   Latency: width+2 cycles for ordinary operands, 1 cycle for zero/NaR.
// -----------------------------------------------------------------------------
module posit_decoded_mul #(
  parameter int width = 32,
  parameter int es    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  posit_decoded_mul_if.slave bus
);
  localparam int SW = width + es + 2;
  localparam int CW = $clog2(width);
  localparam int MW = 2 * width;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [MW-1:0]   acc_q,   acc_d;    // running partial product
  logic [MW-1:0]   ma_q,    ma_d;     // multiplicand, shifted left per step
  logic [width-1:0] mb_q,   mb_d;     // multiplier, shifted right per step
  logic [SW-1:0]   scale_q, scale_d;
  logic [MW-1:0]   mant_q,  mant_d;
  logic            sign_q,  sign_d;
  logic            zero_q,  zero_d;
  logic            nar_q,   nar_d;

  // scale = regime * 2^es + exponent[es-1:0], in two's complement at SW bits.
  // Upper exponent bits from the decoder carry no meaning and are dropped.
  function automatic logic [SW-1:0] to_scale(input logic [width-2:0] regime,
                                             input logic [width-2:0] exponent);
    logic [SW-1:0] r;
    r = {{(SW-width+1){regime[width-2]}}, regime};
    return (r << es) + {{(SW-es){1'b0}}, exponent[es-1:0]};
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    scale_d = scale_q;
    mant_d  = mant_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    nar_d   = nar_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d  = '0;
          mant_d = '0;
          cnt_d  = CW'(width - 1);
          ma_d   = {{width{1'b0}}, 1'b1, bus.a_fraction};
          mb_d   = {1'b1, bus.b_fraction};
          if (bus.a_nar || bus.b_nar) begin
            // NaR dominates zero: 0 * NaR is NaR.
            nar_d   = 1'b1;
            zero_d  = 1'b0;
            sign_d  = 1'b0;
            scale_d = '0;
            state_d = DONE;
          end else if (bus.a_zero || bus.b_zero) begin
            nar_d   = 1'b0;
            zero_d  = 1'b1;
            sign_d  = 1'b0;
            scale_d = '0;
            state_d = DONE;
          end else begin
            nar_d   = 1'b0;
            zero_d  = 1'b0;
            sign_d  = bus.a_sign ^ bus.b_sign;
            scale_d = to_scale(bus.a_regime, bus.a_exponent)
                    + to_scale(bus.b_regime, bus.b_exponent);
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (mb_q[0]) acc_d = acc_q + ma_q;
        ma_d = ma_q << 1;
        mb_d = mb_q >> 1;
        if (cnt_q == '0) state_d = NORM;
        else             cnt_d   = cnt_q - CW'(1);
      end
      NORM: begin
        // Product of two values in [1,2) lies in [1,4): at most one bit of
        // renormalisation is ever needed.
        if (acc_q[MW-1]) begin
          scale_d = scale_q + SW'(1);
          mant_d  = acc_q;
        end else begin
          mant_d  = acc_q << 1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the datapath registers are few, so all are reset to give
  // clean outputs and a clear accumulator even when reset lands mid-multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      scale_q <= '0;
      mant_q  <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      scale_q <= scale_d;
      mant_q  <= mant_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sign  = sign_q;
  assign bus.out_scale = scale_q;
  assign bus.out_mant  = mant_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_nar   = nar_q;
endmodule

// File: tb/tb_posit_decoded_mul.sv
// -----------------------------------------------------------------------------
// tb_posit_decoded_mul
//   Directed bench for posit_decoded_mul. One instance at width=8/es=1 covers
//   reset, arithmetic, specials and back-pressure; a width=32/es=2 instance
//   covers back-to-back re-issue and full-width latency.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_posit_decoded_mul;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  posit_decoded_mul_if #(.width(8),  .es(1)) if8 ();
  posit_decoded_mul_if #(.width(32), .es(2)) if32 ();

  posit_decoded_mul #(.width(8),  .es(1)) u_mul8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  posit_decoded_mul #(.width(32), .es(2)) u_mul32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  task automatic set8(input logic as_, input logic [6:0] ar, ae, af, input logic az, an,
                      input logic bs,  input logic [6:0] br, be, bf, input logic bz, bn);
    if8.a_sign = as_; if8.a_regime = ar; if8.a_exponent = ae; if8.a_fraction = af;
    if8.a_zero = az;  if8.a_nar = an;
    if8.b_sign = bs;  if8.b_regime = br; if8.b_exponent = be; if8.b_fraction = bf;
    if8.b_zero = bz;  if8.b_nar = bn;
  endtask

  task automatic set32(input logic as_, input logic [30:0] ar, ae, af,
                       input logic bs,  input logic [30:0] br, be, bf);
    if32.a_sign = as_; if32.a_regime = ar; if32.a_exponent = ae; if32.a_fraction = af;
    if32.b_sign = bs;  if32.b_regime = br; if32.b_exponent = be; if32.b_fraction = bf;
    if32.a_zero = 1'b0; if32.a_nar = 1'b0; if32.b_zero = 1'b0; if32.b_nar = 1'b0;
  endtask

  // Called at a falling edge with operands on the bus. Counts rising edges,
  // the accept edge being edge 1, until out_valid is seen. A stuck design
  // returns the bound, which the caller's latency comparison rejects.
  task automatic run8(input bit drop, output int lat);
    lat = 0;
    if8.in_valid = 1'b1;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (drop && lat == 1) if8.in_valid = 1'b0;
      if (if8.out_valid || lat >= 200) break;
    end
  endtask

  task automatic run32(input bit drop, output int lat);
    lat = 0;
    if32.in_valid = 1'b1;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (drop && lat == 1) if32.in_valid = 1'b0;
      if (if32.out_valid || lat >= 200) break;
    end
  endtask

  // One result comparison plus one latency comparison for the width=8 core.
  task automatic op8(input string name, input int exp_lat, input logic exp_sign,
                     input logic [10:0] exp_scale, input logic [15:0] exp_mant,
                     input logic exp_zero, input logic exp_nar);
    int lat;
    run8(1'b1, lat);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_vec++;
    if ({if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar} !==
        {exp_sign, exp_scale, exp_mant, exp_zero, exp_nar}) begin
      n_err++;
      $display("FAIL %s result: got sign=%b scale=%h mant=%h zero=%b nar=%b expected sign=%b scale=%h mant=%h zero=%b nar=%b",
               name, if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar,
               exp_sign, exp_scale, exp_mant, exp_zero, exp_nar);
    end
    @(posedge clk);   // result handshake (out_ready high)
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({if8.in_ready, if8.out_valid, if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar} !==
        {1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b sign=%b scale=%h mant=%h zero=%b nar=%b expected rdy=1 vld=0 rest 0",
               if8.in_ready, if8.out_valid, if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar);
    end
    n_vec++;
    if ({if32.in_ready, if32.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_state32: got rdy=%b vld=%b expected rdy=1 vld=0", if32.in_ready, if32.out_valid);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    // 1.0 x 1.0: product 1.0, no renormalisation increment.
    set8(0, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 7'h00, 7'h00, 0, 0);
    op8("one_x_one", 10, 1'b0, 11'h000, 16'h8000, 1'b0, 1'b0);
    // 1.5 x -1.5 = -2.25: product >= 2, scale bumps to 1.
    set8(0, 7'h00, 7'h00, 7'h40, 0, 0, 1, 7'h00, 7'h00, 7'h40, 0, 0);
    op8("1p5_x_m1p5", 10, 1'b1, 11'h001, 16'h9000, 1'b0, 1'b0);
    // 1.5 x 1.25 = 1.875: product < 2, mantissa shifted left.
    set8(1, 7'h00, 7'h00, 7'h40, 0, 0, 1, 7'h00, 7'h00, 7'h20, 0, 0);
    op8("1p5_x_1p25", 10, 1'b0, 11'h000, 16'hF000, 1'b0, 1'b0);
  endtask

  task automatic test_scale;
    // a: regime 2, exponent 1 -> 5 ; b: regime -3, exponent 0 -> -6 ; sum -1.
    // Upper exponent bits are junk that must be ignored.
    set8(0, 7'h02, 7'h7F, 7'h00, 0, 0, 0, 7'h7D, 7'h7E, 7'h00, 0, 0);
    op8("scale_sum", 10, 1'b0, 11'h7FF, 16'h8000, 1'b0, 1'b0);
  endtask

  task automatic test_specials;
    set8(1, 7'h03, 7'h01, 7'h55, 1, 0, 0, 7'h02, 7'h01, 7'h2A, 0, 1);
    op8("zero_and_nar", 1, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b1);
    set8(1, 7'h03, 7'h01, 7'h55, 1, 0, 0, 7'h02, 7'h01, 7'h2A, 0, 0);
    op8("zero_only", 1, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0);
    set8(0, 7'h00, 7'h00, 7'h00, 0, 0, 1, 7'h01, 7'h00, 7'h10, 0, 1);
    op8("nar_only", 1, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_mul;
    set8(0, 7'h00, 7'h00, 7'h40, 0, 0, 1, 7'h01, 7'h01, 7'h40, 0, 0);
    if8.in_valid = 1'b1;
    @(posedge clk);                 // accept edge (cycle 1)
    @(negedge clk); if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);      // now in cycle 4 of MUL
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({if8.in_ready, if8.out_valid, if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar} !==
        {1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_mul: got rdy=%b vld=%b sign=%b scale=%h mant=%h zero=%b nar=%b expected rdy=1 vld=0 rest 0",
               if8.in_ready, if8.out_valid, if8.out_sign, if8.out_scale, if8.out_mant, if8.out_zero, if8.out_nar);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // A fresh operation after the abort must start from a cleared accumulator.
    set8(0, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 7'h00, 7'h00, 0, 0);
    op8("after_reset", 10, 1'b0, 11'h000, 16'h8000, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    int lat;
    if8.out_ready = 1'b0;
    set8(0, 7'h00, 7'h00, 7'h00, 0, 0, 0, 7'h00, 7'h00, 7'h00, 0, 0);
    run8(1'b1, lat);
    n_vec++;
    if (lat !== 10) begin
      n_err++;
      $display("FAIL bp_latency: got %0d expected 10", lat);
    end
    // Second pair offered while the first result is stalled.
    set8(0, 7'h00, 7'h00, 7'h40, 0, 0, 0, 7'h00, 7'h00, 7'h40, 0, 0);
    if8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({if8.out_valid, if8.in_ready, if8.out_sign, if8.out_scale, if8.out_mant} !==
          {1'b1, 1'b0, 1'b0, 11'h000, 16'h8000}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sign=%b scale=%h mant=%h expected vld=1 rdy=0 sign=0 scale=000 mant=8000",
                 i, if8.out_valid, if8.in_ready, if8.out_sign, if8.out_scale, if8.out_mant);
      end
    end
    if8.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);  // handshake edge
    n_vec++;
    if ({if8.out_valid, if8.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", if8.out_valid, if8.in_ready);
    end
    op8("bp_second", 10, 1'b0, 11'h001, 16'h9000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat;
    // a scale 1*4+3 = 7 (junk above exponent bit 1), b scale -1*4+1 = -3.
    set32(1, 31'h0000_0001, 31'h7FFF_FFF3, 31'h0, 0, 31'h7FFF_FFFF, 31'h0000_0001, 31'h0);
    run32(1'b0, lat);
    n_vec++;
    if (lat !== 34) begin
      n_err++;
      $display("FAIL b2b_lat1: got %0d expected 34", lat);
    end
    n_vec++;
    if ({if32.out_sign, if32.out_scale, if32.out_mant, if32.in_ready} !==
        {1'b1, 36'h0_0000_0004, 64'h8000_0000_0000_0000, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_res1: got sign=%b scale=%h mant=%h rdy=%b expected sign=1 scale=000000004 mant=8000000000000000 rdy=0",
               if32.out_sign, if32.out_scale, if32.out_mant, if32.in_ready);
    end
    // Present the second pair; in_valid never drops.
    set32(0, 31'h0, 31'h0, 31'h4000_0000, 0, 31'h0, 31'h0, 31'h4000_0000);
    @(posedge clk); @(negedge clk);  // handshake edge
    n_vec++;
    if ({if32.out_valid, if32.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_idle: got vld=%b rdy=%b expected vld=0 rdy=1", if32.out_valid, if32.in_ready);
    end
    run32(1'b1, lat);
    n_vec++;
    if (lat !== 34) begin
      n_err++;
      $display("FAIL b2b_lat2: got %0d expected 34", lat);
    end
    n_vec++;
    if ({if32.out_sign, if32.out_scale, if32.out_mant, if32.out_zero, if32.out_nar} !==
        {1'b0, 36'h0_0000_0001, 64'h9000_0000_0000_0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_res2: got sign=%b scale=%h mant=%h zero=%b nar=%b expected sign=0 scale=000000001 mant=9000000000000000 zero=0 nar=0",
               if32.out_sign, if32.out_scale, if32.out_mant, if32.out_zero, if32.out_nar);
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.in_valid  = 1'b0; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.out_ready = 1'b1;
    set8(0, 7'h0, 7'h0, 7'h0, 0, 0, 0, 7'h0, 7'h0, 7'h0, 0, 0);
    set32(0, 31'h0, 31'h0, 31'h0, 0, 31'h0, 31'h0, 31'h0);

    test_reset();
    test_basic();
    test_scale();
    test_specials();
    test_reset_mid_mul();
    test_backpressure();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/posit_decoded_mul.md
# posit_decoded_mul

Multi-cycle posit multiplier core. It consumes two operands already split into sign, regime, exponent and fraction fields by the variable-width posit decoder, and produces an unrounded, normalised product as sign, scale and mantissa. The result goes to the downstream posit rounding/encode stage. The mantissa product uses a radix-2 shift-add datapath, trading latency for area, and both sides use valid/ready handshakes.

## Interface
- `width`, 32, posit width; sets the field widths, matching the decoder.
- `es`, 2, exponent field size.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  core can accept an operand pair.
- `a_sign`, `b_sign`  in  1  operand signs.
- `a_regime`, `b_regime`  in  `width-1`  signed regime values.
- `a_exponent`, `b_exponent`  in  `width-1`  signed exponent values; only the low `es` bits are meaningful.
- `a_fraction`, `b_fraction`  in  `width-1`  fraction bits, MSB-aligned; the hidden bit is implicit.
- `a_zero`, `b_zero`, `a_nar`, `b_nar`  in  1  special-value flags from the decode-side special detector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sign`  out  1  product sign.
- `out_scale`  out  `width+es+2`  signed power-of-two scale of the product.
- `out_mant`  out  `2*width`  normalised mantissa, MSB = 1 (weight 2^0) unless the result is zero or NaR.
- `out_zero`, `out_nar`  out  1  result special flags.

## Operation
- **States:** IDLE, MUL, NORM, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, latch all fields:
    - scale_x = regime_x·2^es + exponent_x[es-1:0], sign-extended to `width+es+2`;
    - mantissa_x = {1'b1, fraction_x} (`width` bits).
  - Clear the accumulator.
- **Special operands:**
  - If any nar flag is set: `out_nar`=1, `out_zero`=0.
  - Else if any zero flag is set: `out_zero`=1.
  - In both cases skip MUL/NORM and go directly to DONE. `out_sign`, `out_scale` and `out_mant` are 0.
- **Otherwise:**
  - `out_sign` = a_sign ^ b_sign.
  - Scale sum = scale_a + scale_b.
  - Go to MUL.
- **MUL:** runs exactly `width` cycles, driven by a counter from `width-1` down to 0.
  - Each cycle, if the current LSB of the shifted mantissa_b is 1, add mantissa_a into the accumulator at the aligned position.
  - Shift mantissa_b right.
  - The final accumulator holds the exact `2*width`-bit product.
  - At count 0, go to NORM.
- **NORM (1 cycle):** the product lies in [1,4).
  - If bit `2*width-1` is set: scale += 1, mant = product.
  - Else: mant = product << 1.
  - Go to DONE.
- **DONE:**
  - `out_valid` = 1 and all outputs hold stable until `out_ready`.
  - On `out_valid` & `out_ready`, go to IDLE.
- **No overlap:** `in_ready` is 0 in every state except IDLE, so one operation is in flight at a time.
- **Arithmetic:** all scale arithmetic is signed two's complement at `width+es+2` bits and cannot overflow for any legal decoder output. No rounding is done here.

## Timing
- **Reset** (asynchronous, any state, including mid-MUL):
  - state = IDLE, `in_ready` = 1, `out_valid` = 0;
  - `out_sign`, `out_scale`, `out_mant`, `out_zero`, `out_nar` = 0;
  - counter and accumulator = 0.
- **Latency, normal operand:** `width+2` cycles from the accept edge to `out_valid`: 1 cycle latch, `width` cycles MUL, 1 cycle NORM. For example, 34 cycles at width=32.
- **Latency, special operand:** `out_valid` rises 1 cycle after accept.
- **Back-to-back:**
  - The result handshake in DONE returns to IDLE.
  - `in_ready` rises in the cycle after `out_valid`&`out_ready`.
  - Minimum issue interval is `width+3` cycles.
- **Back-pressure:** `out_ready` = 0 holds DONE indefinitely with outputs unchanged. `in_valid` asserted outside IDLE is ignored and not accepted.

## Test plan
All scenarios use width=8, es=1 unless noted.
- **Reset mid-MUL:** accept an operand pair, assert `rst_n`=0 at cycle 4, release → `out_valid`=0 and `in_ready`=1 immediately; all outputs 0.
- **1.0 × 1.0:** regime 0, exponent 0, fraction 0, both signs 0 → after 10 cycles, `out_mant`=16'h8000, `out_scale`=0, `out_sign`=0.
- **1.5 × −1.5:** fraction 7'h40, b_sign=1, regime 0 → `out_mant`=16'h9000, `out_scale`=1, `out_sign`=1.
- **Scale sum:** a regime=2, exponent=1 (scale 5); b regime=−3, exponent=0 (scale −6); fractions 0 → `out_scale`=−1, `out_mant`=16'h8000.
- **Specials:** a_zero=1 with b_nar=1 → `out_nar`=1, `out_zero`=0, 1-cycle latency. a_zero=1 alone → `out_zero`=1.
- **Back-pressure and re-issue:** hold `out_ready`=0 for 5 cycles, outputs stable; issue a second pair while busy → not accepted until the cycle after the first result handshake; at width=32 the second result arrives 34 cycles after its accept.
